// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/subtract unit split into WIDTH/GROUP pipeline stages.
// Each stage resolves one GROUP-bit slice with generate/propagate lookahead,
// using the carry registered by the previous stage. The pipeline moves as a
// whole; a stall freezes every stage, including bubbles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The pipeline advances when the output register is empty or being
// drained (advance = !out_valid || out_ready); in_ready = advance && !rst.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set present on a, b, ci, sub
//   in_ready   operand set accepted this cycle if in_valid=1
//   a, b       WIDTH-bit operands
//   ci         carry-in (add mode only)
//   sub        0 = a + b + ci, 1 = a - b (a + ~b + 1)
//   out_valid  sum/co/ovf hold a completed result
//   out_ready  downstream accepts the result this cycle
//   sum        WIDTH-bit result
//   co         carry-out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int GROUP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;
  localparam int LAST   = STAGES - 1;

  // Per-stage registers: stage k holds sum bits [(k+1)*GROUP-1:0] complete,
  // the operands still to be summed (b already inverted when subtracting),
  // the carry out of the completed slices, and the operand sign bits.
  logic [STAGES-1:0]            st_valid;
  logic [STAGES-1:0][WIDTH-1:0] st_sum;
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0]            st_sa;
  logic [STAGES-1:0]            st_sb;

  logic [STAGES-1:0]            nxt_valid;
  logic [STAGES-1:0][WIDTH-1:0] nxt_sum;
  logic [STAGES-1:0][WIDTH-1:0] nxt_a;
  logic [STAGES-1:0][WIDTH-1:0] nxt_b;
  logic [STAGES-1:0]            nxt_c;
  logic [STAGES-1:0]            nxt_sa;
  logic [STAGES-1:0]            nxt_sb;

  logic             advance;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic             c_mode;
  logic [GROUP:0]   res;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign take     = in_valid && in_ready;

  // One GROUP-bit lookahead slice: returns {carry_out, slice_sum}.
  function automatic logic [GROUP:0] slice_add(input logic [GROUP-1:0] x,
                                               input logic [GROUP-1:0] y,
                                               input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  always_comb begin
    b_eff     = sub ? ~b : b;
    c_mode    = sub ? 1'b1 : ci;
    nxt_valid = '0;
    nxt_sum   = '0;
    nxt_a     = '0;
    nxt_b     = '0;
    nxt_c     = '0;
    nxt_sa    = '0;
    nxt_sb    = '0;

    // Stage 0. A bubble enters as all-zero data so that it propagates as a
    // clean 0 + 0 result rather than whatever sits on the operand pins.
    res = slice_add(a[GROUP-1:0], b_eff[GROUP-1:0], c_mode);
    if (take) begin
      nxt_valid[0]            = 1'b1;
      nxt_a[0]                = a;
      nxt_b[0]                = b_eff;
      nxt_sum[0][GROUP-1:0]   = res[GROUP-1:0];
      nxt_c[0]                = res[GROUP];
      nxt_sa[0]               = a[WIDTH-1];
      nxt_sb[0]               = b_eff[WIDTH-1];
    end

    // Stages 1..LAST: resolve slice k from the carry left by stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      res = slice_add(st_a[k-1][k*GROUP +: GROUP],
                      st_b[k-1][k*GROUP +: GROUP],
                      st_c[k-1]);
      nxt_valid[k]                = st_valid[k-1];
      nxt_a[k]                    = st_a[k-1];
      nxt_b[k]                    = st_b[k-1];
      nxt_sum[k]                  = st_sum[k-1];
      nxt_sum[k][k*GROUP +: GROUP] = res[GROUP-1:0];
      nxt_c[k]                    = res[GROUP];
      nxt_sa[k]                   = st_sa[k-1];
      nxt_sb[k]                   = st_sb[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_sum   <= '0;
      st_a     <= '0;
      st_b     <= '0;
      st_c     <= '0;
      st_sa    <= '0;
      st_sb    <= '0;
    end else if (advance) begin
      st_valid <= nxt_valid;
      st_sum   <= nxt_sum;
      st_a     <= nxt_a;
      st_b     <= nxt_b;
      st_c     <= nxt_c;
      st_sa    <= nxt_sa;
      st_sb    <= nxt_sb;
    end
  end

  assign out_valid = st_valid[LAST];
  assign sum       = st_sum[LAST];
  assign co        = st_c[LAST];
  // Overflow: operand signs agree but the result sign differs.
  assign ovf       = (st_sa[LAST] == st_sb[LAST]) &&
                     (st_sum[LAST][WIDTH-1] != st_sa[LAST]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=8, GROUP=2, four stages).
module tb_pipelined_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  int n_checks = 0;
  int n_err    = 0;

  // Expected results in acceptance order: {ovf, co, sum}.
  logic [W+1:0] exp_q[$];

  pipelined_addsub #(.WIDTH(W), .GROUP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model using integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                         input logic [W-1:0] mb,
                                         input logic mci, input logic msub);
    int ua, ub, sa, sb, t, s;
    logic [W-1:0] rs;
    logic rc, rv;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (msub) begin
      t  = ua - ub;
      rc = (ua >= ub);
      s  = sa - sb;
    end else begin
      t  = ua + ub + int'(mci);
      rc = (t > 255);
      s  = sa + sb + int'(mci);
    end
    rs = W'((t + 256) % 256);
    rv = (s > 127) || (s < -128);
    return {rv, rc, rs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver task: called at a negedge with inputs already driven. Checks the
  // visible output against the scoreboard, then advances one clock edge.
  task automatic cycle();
    logic         do_pop, do_push, exp_rdy;
    logic [W+1:0] ev;
    #1;
    exp_rdy = !rst && (!out_valid || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else chk("result", 32'({ovf, co, sum}), 32'(exp_q[0]));
    end
    do_pop  = (out_valid === 1'b1) && out_ready && !rst;
    do_push = in_valid && (in_ready === 1'b1);
    ev      = model(a, b, ci, sub);
    @(posedge clk);
    if (rst) exp_q.delete();
    else begin
      if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ev);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] da,
                       input logic [W-1:0] db, input logic dci,
                       input logic dsub);
    in_valid = v;
    a        = da;
    b        = db;
    ci       = dci;
    sub      = dsub;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset
    cycle();
    drive_rand(1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({ovf, co, sum}), 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Add with signed overflow, latency check
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("lat_e0", 32'(out_valid), 32'd0);
    cycle();
    chk("lat_e1", 32'(out_valid), 32'd0);
    cycle();
    chk("lat_e2", 32'(out_valid), 32'd0);
    cycle();
    chk("lat_e3", 32'(out_valid), 32'd1);
    chk("add_7f_01", 32'({ovf, co, sum}), 32'({1'b1, 1'b0, 8'h80}));
    cycle();

    // Subtract pair
    drive(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("sub_05_07", 32'({out_valid, ovf, co, sum}),
        32'({1'b1, 1'b0, 1'b0, 8'hFE}));
    cycle();
    chk("sub_80_01", 32'({out_valid, ovf, co, sum}),
        32'({1'b1, 1'b1, 1'b1, 8'h7F}));
    cycle();

    // Carry through every slice
    drive(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("carry_chain", 32'({out_valid, ovf, co, sum}),
        32'({1'b1, 1'b0, 1'b1, 8'h00}));
    cycle();
    chk("drained_1", 32'(exp_q.size()), 32'd0);

    // Streaming: 16 back-to-back ops, results on consecutive cycles
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive_rand(1'b1);
      else drive(1'b0, '0, '0, 1'b0, 1'b0);
      cycle();
      chk("stream_out_valid", 32'(out_valid), (i >= 3 && i < 19) ? 32'd1 : 32'd0);
    end
    chk("drained_2", 32'(exp_q.size()), 32'd0);

    // Backpressure: fill the pipe, stall 5 cycles, then drain
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_resume_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("drained_3", 32'(exp_q.size()), 32'd0);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    rst = 1'b1;
    drive_rand(1'b1);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    cycle();
    rst = 1'b0;
    drive(1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0);
    #1;
    chk("midrst_after_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_quiet", 32'({out_valid, ovf, co, sum}), 32'd0);
      cycle();
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle();
    chk("drained_final", 32'(exp_q.size()), 32'd0);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
